clkgen_ctrl: RTL and testbench
==============================

// Module: clkgen_ctrl
// PURPOSE
//  Synthesizable programmable clock generator and its configuration controller.
//  Derives a registered output clock from clk with programmable phase delay,
//  high time and low time, all in clk cycles. It replaces behavioural delay-based
//  clock tasks in RTL. Config arrives over a valid/ready port and is applied only
//  on period boundaries, so clk_out never produces a runt pulse.
// PARAMETERS
//  CNT_W       16  width of phase/ton/toff fields and internal down-counters
//  DEF_TON     1   reset high time, in cycles
//  DEF_TOFF    1   reset low time, in cycles (reset output = clk/2)
// PORTS
//  clk         in   1      single system clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  cfg_valid   in   1      config offer
//  cfg_ready   out  1      controller can accept a config
//  cfg_phase   in   CNT_W  cycles from start to first high; used only when starting from IDLE
//  cfg_ton     in   CNT_W  high time; legal range 1..2^CNT_W-1
//  cfg_toff    in   CNT_W  low time; legal range 1..2^CNT_W-1
//  cfg_err     out  1      1-cycle pulse: offered config rejected
//  en          in   1      run request (level)
//  clk_out     out  1      generated clock, registered
//  running     out  1      state != IDLE
//  period_tick out  1      1-cycle pulse on the last LOW cycle of each period
// BEHAVIOUR
//  Reset values (asynchronous, immediate):
//   - clk_out=0, running=0, period_tick=0, cfg_err=0, cfg_ready=1
//   - active cfg = {phase 0, DEF_TON, DEF_TOFF}; shadow empty; state IDLE
//  FSM states: IDLE, PHASE, HIGH, LOW. Each state uses a down-counter loaded with N-1.
//   - IDLE:
//     - en=1 at edge k -> PHASE if phase>0, else HIGH.
//     - clk_out first rises after edge k+1+phase.
//   - PHASE: counts phase cycles with clk_out=0, then -> HIGH.
//   - HIGH: clk_out=1 for ton cycles, then -> LOW.
//   - LOW: clk_out=0 for toff cycles. On its last cycle: period_tick=1, apply shadow
//     if full, then -> HIGH if en=1, else -> IDLE.
//  Config handshake (transfer = cfg_valid && cfg_ready):
//   - ton==0 or toff==0: reject; cfg_err=1 on the next cycle; nothing changes.
//   - Legal config in IDLE: becomes the active cfg on the next cycle; cfg_ready stays 1.
//   - Legal config while running: loaded into shadow; cfg_ready=0 until the shadow is
//     applied at the next LOW-end boundary; cfg_ready returns to 1 the cycle after.
//   - Config accepted in the boundary cycle itself applies at the following boundary.
//   - New phase is stored but takes effect only on the next start from IDLE.
//  Stop rules:
//   - en=0 during HIGH or LOW: the current period completes in full, then -> IDLE.
//   - en=0 during PHASE: -> IDLE next cycle (clk_out is already 0).
//   - en re-asserted before the end of LOW: continuous running, no gap.
//   - Shadow still full on entry to IDLE: applied on the IDLE entry cycle.
//  Width rules: counters are CNT_W bits and never wrap. Period = ton+toff cycles,
//  up to 2^(CNT_W+1)-2. Duty = ton/(ton+toff).
//  Reset mid-operation: clk_out drops asynchronously; pending shadow is discarded.
// STRUCTURE
//  Package clkgen_pkg:
//   - typedef enum state_t {IDLE, PHASE, HIGH, LOW}
//   - typedef struct clk_cfg_t {phase, ton, toff}
//   - DEF_* constants
//  Sub-module clkgen_cfg_shadow: valid/ready handshake, legality check, cfg_err,
//  shadow register, apply strobe input. FSM and counters stay in clkgen_ctrl.
// TESTING
//  1 Reset, then en=1 with defaults -> clk_out toggles every cycle; period_tick every 2nd cycle.
//  2 IDLE cfg {3,2,3}, en=1 at edge k -> clk_out rises after edge k+4; high 2, low 3; tick every 5.
//  3 Running {1,2,3}, cfg {0,4,4} mid-HIGH -> old period completes; cfg_ready=0 until boundary; next period 4/4.
//  4 cfg_ton=0 offered -> cfg_err pulse next cycle; cfg_ready stays 1; waveform unchanged.
//  5 en=0 mid-HIGH -> HIGH+LOW complete, tick, running=0; en=0 in PHASE(5) -> IDLE next cycle, clk_out never 1.
//  6 rst_n low mid-HIGH between edges -> clk_out=0 immediately; after release defaults and cfg_ready=1.

Source files
------------

// File: rtl/clkgen_pkg.sv
// Shared types and constants for the programmable clock generator.
package clkgen_pkg;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DEF_TON  = 1;
    localparam int unsigned DEF_TOFF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] phase;
        logic [CNT_W-1:0] ton;
        logic [CNT_W-1:0] toff;
    } clk_cfg_t;

endpackage

// File: rtl/clkgen_cfg_shadow.sv
// Config port: valid/ready handshake, legality check, shadow register and active config.
module clkgen_cfg_shadow
    import clkgen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic [CNT_W-1:0] cfg_ton,
    input  logic [CNT_W-1:0] cfg_toff,
    output logic             cfg_err,
    input  logic             idle,
    input  logic             apply,
    output clk_cfg_t         cfg_nxt_c
);

    clk_cfg_t active;
    clk_cfg_t shadow;
    clk_cfg_t offer_c;
    logic     legal_c;
    logic     xfer_c;

    // cfg_ready low means the shadow holds a pending config
    always_comb begin
        offer_c   = '{phase: cfg_phase, ton: cfg_ton, toff: cfg_toff};
        legal_c   = (cfg_ton != '0) && (cfg_toff != '0);
        xfer_c    = cfg_valid && cfg_ready;
        cfg_nxt_c = active;
        if (apply && !cfg_ready) begin
            cfg_nxt_c = shadow;
        end else if (xfer_c && legal_c && idle) begin
            cfg_nxt_c = offer_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= '{phase: '0, ton: CNT_W'(DEF_TON), toff: CNT_W'(DEF_TOFF)};
            shadow    <= '0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            active  <= cfg_nxt_c;
            cfg_err <= xfer_c && !legal_c;
            if (xfer_c && legal_c && !idle) begin
                shadow    <= offer_c;
                cfg_ready <= 1'b0;
            end else if (apply && !cfg_ready) begin
                cfg_ready <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkgen_ctrl.sv
// Programmable clock generator: phase delay, high and low times counted in clk cycles.
module clkgen_ctrl
    import clkgen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_phase,
    input  logic [CNT_W-1:0] cfg_ton,
    input  logic [CNT_W-1:0] cfg_toff,
    output logic             cfg_err,
    input  logic             en,
    output logic             clk_out,
    output logic             running,
    output logic             period_tick
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    clk_cfg_t         cfg_nxt;
    logic             last_c;
    logic             apply_c;

    // Shadow applies at each period end and on any cycle spent in IDLE
    assign last_c  = (cnt == '0);
    assign apply_c = (state == IDLE) || ((state == LOW) && last_c);

    clkgen_cfg_shadow u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_phase (cfg_phase),
        .cfg_ton   (cfg_ton),
        .cfg_toff  (cfg_toff),
        .cfg_err   (cfg_err),
        .idle      (state == IDLE),
        .apply     (apply_c),
        .cfg_nxt_c (cfg_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counters are loaded with N-1 from the config that is active in the next cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (en) begin
                    if (cfg_nxt.phase != '0) begin
                        state_nxt = PHASE;
                        cnt_nxt   = cfg_nxt.phase - CNT_W'(1);
                    end else begin
                        state_nxt = HIGH;
                        cnt_nxt   = cfg_nxt.ton - CNT_W'(1);
                    end
                end
            end
            PHASE: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (last_c) begin
                    state_nxt = HIGH;
                    cnt_nxt   = cfg_nxt.ton - CNT_W'(1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            HIGH: begin
                if (last_c) begin
                    state_nxt = LOW;
                    cnt_nxt   = cfg_nxt.toff - CNT_W'(1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            LOW: begin
                if (last_c) begin
                    state_nxt = en ? HIGH : IDLE;
                    cnt_nxt   = en ? (cfg_nxt.ton - CNT_W'(1)) : '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs lag the state by one cycle so clk_out is a clean flop output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_out     <= 1'b0;
            running     <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            clk_out     <= (state == HIGH);
            running     <= (state != IDLE);
            period_tick <= (state == LOW) && last_c;
        end
    end

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Self-checking bench for clkgen_ctrl: cycle tables with a scoreboard plus a reset sequence.
module tb_clkgen_ctrl;
    import clkgen_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_phase;
    logic [CNT_W-1:0] cfg_ton;
    logic [CNT_W-1:0] cfg_toff;
    logic             cfg_err;
    logic             en;
    logic             clk_out;
    logic             running;
    logic             period_tick;

    clkgen_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_phase   (cfg_phase),
        .cfg_ton     (cfg_ton),
        .cfg_toff    (cfg_toff),
        .cfg_err     (cfg_err),
        .en          (en),
        .clk_out     (clk_out),
        .running     (running),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bits: {clk_out, period_tick, running, cfg_ready, cfg_err}
    logic [4:0] obs;
    assign obs = {clk_out, period_tick, running, cfg_ready, cfg_err};

    typedef struct {
        logic             en;
        logic             valid;
        logic [CNT_W-1:0] phase;
        logic [CNT_W-1:0] ton;
        logic [CNT_W-1:0] toff;
        logic [4:0]       exp;
    } vec_t;

    vec_t       tbl[$];
    logic [4:0] sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (clk_out,tick,running,ready,err)", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic v, input int p, input int on, input int off,
                       input logic [4:0] exp);
        vec_t r;
        r.en = e; r.valid = v;
        r.phase = CNT_W'(p); r.ton = CNT_W'(on); r.toff = CNT_W'(off);
        r.exp = exp;
        tbl.push_back(r);
    endtask

    // Called at a negedge: drive one cycle, expect outputs after the following posedge
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            en        = tbl[i].en;
            cfg_valid = tbl[i].valid;
            cfg_phase = tbl[i].phase;
            cfg_ton   = tbl[i].ton;
            cfg_toff  = tbl[i].toff;
            sb.push_back(tbl[i].exp);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), obs, sb.pop_front());
        end
        cfg_valid = 1'b0;
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        cfg_phase = '0; cfg_ton = '0; cfg_toff = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold", obs, 5'b00010);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_release", obs, 5'b00010);

        // Defaults: clk/2, tick every second cycle, then stop at period end
        add(1,0,0,0,0,5'b00010); add(1,0,0,0,0,5'b10110); add(1,0,0,0,0,5'b01110);
        add(1,0,0,0,0,5'b10110); add(1,0,0,0,0,5'b01110); add(1,0,0,0,0,5'b10110);
        add(0,0,0,0,0,5'b01110); add(0,0,0,0,0,5'b00010);
        // Config {3,2,3} in IDLE, start: first rise after edge k+4
        add(0,1,3,2,3,5'b00010); add(1,0,0,0,0,5'b00010); add(1,0,0,0,0,5'b00110);
        add(1,0,0,0,0,5'b00110); add(1,0,0,0,0,5'b00110); add(1,0,0,0,0,5'b10110);
        add(1,0,0,0,0,5'b10110); add(1,0,0,0,0,5'b00110); add(1,0,0,0,0,5'b00110);
        add(1,0,0,0,0,5'b01110); add(1,0,0,0,0,5'b10110); add(1,0,0,0,0,5'b10110);
        add(1,0,0,0,0,5'b00110); add(1,0,0,0,0,5'b00110); add(1,0,0,0,0,5'b01110);
        // ton=0 rejected while running: err pulse, waveform unchanged
        add(1,1,0,0,5,5'b10111); add(1,0,0,0,0,5'b10110); add(1,0,0,0,0,5'b00110);
        add(1,0,0,0,0,5'b00110); add(1,0,0,0,0,5'b01110);
        // {0,4,4} offered mid-HIGH: old period completes, then 4/4
        add(1,1,0,4,4,5'b10100); add(1,0,0,0,0,5'b10100); add(1,0,0,0,0,5'b00100);
        add(1,0,0,0,0,5'b00100); add(1,0,0,0,0,5'b01110); add(1,0,0,0,0,5'b10110);
        add(1,0,0,0,0,5'b10110); add(1,0,0,0,0,5'b10110); add(1,0,0,0,0,5'b10110);
        add(1,0,0,0,0,5'b00110); add(1,0,0,0,0,5'b00110); add(1,0,0,0,0,5'b00110);
        add(1,0,0,0,0,5'b01110);
        // en=0 mid-HIGH: full period completes, tick, then idle
        add(0,0,0,0,0,5'b10110); add(0,0,0,0,0,5'b10110); add(0,0,0,0,0,5'b10110);
        add(0,0,0,0,0,5'b10110); add(0,0,0,0,0,5'b00110); add(0,0,0,0,0,5'b00110);
        add(0,0,0,0,0,5'b00110); add(0,0,0,0,0,5'b01110); add(0,0,0,0,0,5'b00010);
        add(0,0,0,0,0,5'b00010);
        // Phase 5, en dropped inside PHASE: idle next cycle, clk_out never high
        add(0,1,5,4,4,5'b00010); add(1,0,0,0,0,5'b00010); add(1,0,0,0,0,5'b00110);
        add(0,0,0,0,0,5'b00110); add(0,0,0,0,0,5'b00010); add(0,0,0,0,0,5'b00010);
        // toff=0 rejected in IDLE
        add(0,1,1,5,0,5'b00011); add(0,0,0,0,0,5'b00010);
        run_table("main");

        // Start {5,4,4}, fill shadow, then reset asynchronously mid-HIGH
        en = 1'b1;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        cfg_valid = 1'b1; cfg_phase = '0; cfg_ton = CNT_W'(3); cfg_toff = CNT_W'(3);
        @(posedge clk); @(negedge clk);
        cfg_valid = 1'b0;
        chk("shadow_full_ready", {4'b0, cfg_ready}, 5'b00000);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            seen = clk_out;
        end
        chk("reach_high", {4'b0, seen}, 5'b00001);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", obs, 5'b00010);
        @(negedge clk);
        rst_n = 1'b1;

        // Defaults restored; config taken in the boundary cycle applies one period later
        add(1,0,0,0,0,5'b00010); add(1,0,0,0,0,5'b10110); add(1,1,0,2,2,5'b01100);
        add(1,0,0,0,0,5'b10100); add(1,0,0,0,0,5'b01110); add(1,0,0,0,0,5'b10110);
        add(1,0,0,0,0,5'b10110); add(1,0,0,0,0,5'b00110); add(1,0,0,0,0,5'b01110);
        add(1,0,0,0,0,5'b10110);
        run_table("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
